// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant.
// A grant is held until the consumer signals done. Priority then rotates
// past the requester that was just served. IDLE always sits between two
// grants, so o_valid drops for at least one cycle between them.
module rr_onehot_arbiter #(
    parameter  int LEN  = 4,
    localparam int PTRW = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [LEN-1:0]  i_req,
    input  logic            i_done,
    output logic [LEN-1:0]  o_grant,
    output logic            o_valid,
    output logic [PTRW-1:0] o_ptr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [PTRW-1:0]   idx;        // index of the requester currently granted
    logic [PTRW-1:0]   idx_n;
    logic [LEN-1:0]    grant_n;
    logic              valid_n;
    logic [PTRW-1:0]   ptr_n;

    // Search results: hi = first request at or above the pointer,
    // lo = first request anywhere (used when the search has to wrap).
    logic              found_hi, found_lo;
    logic [PTRW-1:0]   win_hi, win_lo;
    logic [LEN-1:0]    oh_hi, oh_lo;

    // Rotating priority search, split into a masked and an unmasked pass.
    // Descending loops leave the lowest matching index as the winner.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        oh_hi    = '0;
        oh_lo    = '0;
        for (int unsigned k = LEN; k > 0; k--) begin
            if (i_req[k-1]) begin
                found_lo = 1'b1;
                win_lo   = PTRW'(k - 1);
                oh_lo    = '0;
                oh_lo[k-1] = 1'b1;
                if ((k - 1) >= 32'(o_ptr)) begin
                    found_hi = 1'b1;
                    win_hi   = PTRW'(k - 1);
                    oh_hi    = '0;
                    oh_hi[k-1] = 1'b1;
                end
            end
        end
    end

    // Next-state logic and next values for the registered outputs.
    always_comb begin
        state_n = state;
        grant_n = o_grant;
        valid_n = o_valid;
        ptr_n   = o_ptr;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (found_lo) begin
                    state_n = GRANT;
                    valid_n = 1'b1;
                    grant_n = found_hi ? oh_hi : oh_lo;
                    idx_n   = found_hi ? win_hi : win_lo;
                end
            end
            GRANT: begin
                if (i_done) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    grant_n = '0;
                    // LEN need not be a power of 2, so the wrap is an explicit compare.
                    ptr_n   = (idx == PTRW'(LEN - 1)) ? '0 : idx + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                grant_n = '0;
            end
        endcase
    end

    // State and output registers; synchronous reset has priority over all inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_grant <= '0;
            o_valid <= 1'b0;
            o_ptr   <= '0;
            idx     <= '0;
        end else begin
            state   <= state_n;
            o_grant <= grant_n;
            o_valid <= valid_n;
            o_ptr   <= ptr_n;
            idx     <= idx_n;
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed self-checking bench for rr_onehot_arbiter (LEN=4 and LEN=3).
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] ptr;

    logic       rst3 = 1'b0;
    logic [2:0] req3 = '0;
    logic       done3 = 1'b0;
    logic [2:0] grant3;
    logic       valid3;
    logic [1:0] ptr3;

    int compared = 0;
    int mismatched = 0;
    bit inv_on = 1'b0;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.LEN(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_done(done),
        .o_grant(grant), .o_valid(valid), .o_ptr(ptr)
    );

    rr_onehot_arbiter #(.LEN(3)) dut3 (
        .i_clk(clk), .i_rst(rst3), .i_req(req3), .i_done(done3),
        .o_grant(grant3), .o_valid(valid3), .o_ptr(ptr3)
    );

    // Zero-or-one-hot grant and o_valid consistency on both instances, every cycle.
    always @(negedge clk) begin
        if (inv_on) begin
            compared++;
            if (!$onehot0(grant) || (valid !== (grant != 4'b0))) begin
                mismatched++;
                $display("FAIL invariant4 t=%0t grant=%b valid=%b", $time, grant, valid);
            end
            compared++;
            if (!$onehot0(grant3) || (valid3 !== (grant3 != 3'b0)) || (ptr3 === 2'd3)) begin
                mismatched++;
                $display("FAIL invariant3 t=%0t grant=%b valid=%b ptr=%0d", $time, grant3, valid3, ptr3);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; done = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            inv_on = 1'b1;
            compared++;
            if (grant !== 4'b0 || valid !== 1'b0 || ptr !== 2'd0) begin
                mismatched++;
                $display("FAIL reset_hold cyc=%0d got grant=%b valid=%b ptr=%0d want 0000/0/0", c, grant, valid, ptr);
            end
        end
        rst = 1'b0; done = 1'b0;
        step();
        compared++;
        if (grant !== 4'b0001 || valid !== 1'b1 || ptr !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_first_grant got grant=%b valid=%b ptr=%0d want 0001/1/0", grant, valid, ptr);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; done = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            compared++;
            if (grant !== 4'b0100 || valid !== 1'b1) begin
                mismatched++;
                $display("FAIL single_hold cyc=%0d got grant=%b valid=%b want 0100/1", c, grant, valid);
            end
            if (c < 4) step();
        end
        done = 1'b1;
        step();
        done = 1'b0; req = 4'b0000;
        compared++;
        if (grant !== 4'b0000 || valid !== 1'b0 || ptr !== 2'd3) begin
            mismatched++;
            $display("FAIL single_done got grant=%b valid=%b ptr=%0d want 0000/0/3", grant, valid, ptr);
        end
        // done in IDLE must be ignored
        done = 1'b1;
        step();
        done = 1'b0;
        compared++;
        if (grant !== 4'b0000 || valid !== 1'b0 || ptr !== 2'd3) begin
            mismatched++;
            $display("FAIL idle_done_ignored got grant=%b valid=%b ptr=%0d want 0000/0/3", grant, valid, ptr);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_p [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            compared++;
            if (grant !== exp_g[i] || valid !== 1'b1 || ptr !== exp_p[i]) begin
                mismatched++;
                $display("FAIL rotation_grant[%0d] got grant=%b valid=%b ptr=%0d want %b/1/%0d",
                         i, grant, valid, ptr, exp_g[i], exp_p[i]);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            compared++;
            if (grant !== 4'b0000 || valid !== 1'b0) begin
                mismatched++;
                $display("FAIL rotation_gap[%0d] got grant=%b valid=%b want 0000/0", i, grant, valid);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_skip_wrap();
        do_reset();
        req = 4'b0100;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        compared++;
        if (ptr !== 2'd3) begin
            mismatched++;
            $display("FAIL wrap_setup_ptr got %0d want 3", ptr);
        end
        req = 4'b0011;
        step();
        compared++;
        if (grant !== 4'b0001 || valid !== 1'b1) begin
            mismatched++;
            $display("FAIL wrap_grant got grant=%b valid=%b want 0001/1", grant, valid);
        end
        // request change at the done edge is not evaluated yet
        done = 1'b1; req = 4'b1000;
        step();
        done = 1'b0; req = 4'b0000;
        compared++;
        if (grant !== 4'b0000 || valid !== 1'b0 || ptr !== 2'd1) begin
            mismatched++;
            $display("FAIL wrap_done got grant=%b valid=%b ptr=%0d want 0000/0/1", grant, valid, ptr);
        end
    endtask

    task automatic test_withdraw_reset();
        // ptr is 1 from the previous test
        req = 4'b0010;
        step();
        compared++;
        if (grant !== 4'b0010 || valid !== 1'b1) begin
            mismatched++;
            $display("FAIL withdraw_grant got grant=%b valid=%b want 0010/1", grant, valid);
        end
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            compared++;
            if (grant !== 4'b0010 || valid !== 1'b1) begin
                mismatched++;
                $display("FAIL withdraw_hold cyc=%0d got grant=%b valid=%b want 0010/1", c, grant, valid);
            end
        end
        done = 1'b1;
        step();
        done = 1'b0;
        compared++;
        if (grant !== 4'b0000 || ptr !== 2'd2) begin
            mismatched++;
            $display("FAIL withdraw_done got grant=%b ptr=%0d want 0000/2", grant, ptr);
        end
        req = 4'b0010;
        step();
        compared++;
        if (grant !== 4'b0010 || valid !== 1'b1) begin
            mismatched++;
            $display("FAIL regrant got grant=%b valid=%b want 0010/1", grant, valid);
        end
        rst = 1'b1; done = 1'b1;
        step();
        rst = 1'b0; done = 1'b0; req = 4'b0000;
        compared++;
        if (grant !== 4'b0000 || valid !== 1'b0 || ptr !== 2'd0) begin
            mismatched++;
            $display("FAIL mid_grant_reset got grant=%b valid=%b ptr=%0d want 0000/0/0", grant, valid, ptr);
        end
    endtask

    task automatic test_len3();
        logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [1:0] exp_p [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        rst3 = 1'b1;
        step();
        rst3 = 1'b0; req3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (grant3 !== exp_g[i] || valid3 !== 1'b1 || ptr3 !== exp_p[i]) begin
                mismatched++;
                $display("FAIL len3_grant[%0d] got grant=%b valid=%b ptr=%0d want %b/1/%0d",
                         i, grant3, valid3, ptr3, exp_g[i], exp_p[i]);
            end
            done3 = 1'b1;
            step();
            done3 = 1'b0;
        end
        compared++;
        if (ptr3 !== 2'd1 || valid3 !== 1'b0) begin
            mismatched++;
            $display("FAIL len3_final got ptr=%0d valid=%b want 1/0", ptr3, valid3);
        end
        req3 = '0;
    endtask

    initial begin
        rst3 = 1'b1;
        #2;
        test_reset();
        test_single();
        test_rotation();
        test_skip_wrap();
        test_withdraw_reset();
        test_len3();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that picks one of LEN requesters and drives a registered one-hot grant vector.
- Sits directly upstream of the one-hot to natural-binary encoder in the ALU operation-select path.
- The grant vector feeds the encoder input; the encoder's binary output selects the ALU operation or source.
- A grant is held until the consumer signals completion, then priority rotates past the served requester.

Parameters:
- LEN, 4: number of requesters and width of the one-hot grant. Legal range is LEN >= 1; LEN need not be a power of 2.
- PTRW, $clog2(LEN) (minimum 1), localparam: width of the internal priority pointer.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_req  input  LEN  request vector, one bit per requester; any number of bits may be set.
- i_done  input  1  consumer finished with the current grant; sampled only in GRANT.
- o_grant  output  LEN  registered grant; exactly one bit set in GRANT, all zero in IDLE.
- o_valid  output  1  registered; high exactly while o_grant is one-hot (state GRANT).
- o_ptr  output  PTRW  registered priority pointer: the index searched first at the next arbitration.

Behaviour:
- Reset: i_rst is sampled on the rising edge of i_clk and is synchronous, active-high.
  - Reset has priority over every other input.
  - After a reset edge: state=IDLE, o_grant=0, o_valid=0, o_ptr=0.
- FSM states are IDLE and GRANT.
- IDLE:
  - If i_req==0, stay in IDLE; outputs unchanged (zero).
  - If i_req!=0, search indices o_ptr, o_ptr+1, ..., LEN-1, 0, ..., o_ptr-1 and take the first index k with i_req[k]=1.
  - Next edge: o_grant=(1<<k), o_valid=1, state=GRANT.
  - Latency: request sampled at edge n, grant visible after edge n+1 (one cycle).
  - i_done is ignored in IDLE.
- GRANT:
  - o_grant and o_valid are held constant while i_done=0, regardless of i_req; withdrawing the request does not revoke the grant.
  - If i_done=1 at an edge: o_grant=0, o_valid=0, o_ptr=(k+1) mod LEN, state=IDLE.
  - Wrap-around: k=LEN-1 gives o_ptr=0. Explicit compare is required, because LEN is not necessarily a power of 2.
- Turnaround: at least one IDLE cycle always separates consecutive grants, so o_valid drops for at least one cycle between grants.
- Fairness: with all requests held high, the grant sequence is 0,1,...,LEN-1,0,...
- Simultaneous events:
  - i_rst together with i_done: reset wins, and o_ptr=0.
  - i_req changing in the same cycle as i_done: the new i_req is not evaluated until the following IDLE cycle.
- Reset mid-GRANT: the grant is dropped at the reset edge and the pointer returns to 0. The consumer must tolerate this.
- Invariant: o_grant is zero or one-hot at every cycle, never multi-hot. The downstream encoder's all-ones error code therefore appears only when o_valid=0.
- LEN=1: o_ptr stays 0; the grant is bit 0 whenever requested.
- No combinational path from any input to any output.

Test Plan:
- Reset check: assert i_rst for 2 cycles with i_req=4'b1111 and i_done=1. Required: o_grant=0, o_valid=0, o_ptr=0 throughout, and the first grant appears only after i_rst is released.
- Single request: i_req=4'b0100 at edge n, i_done=0. Required after edge n+1: o_grant=4'b0100, o_valid=1, held for 5 cycles. Then i_done=1 for 1 cycle gives o_grant=0 and o_ptr=3.
- Rotation: i_req=4'b1111 held, i_done pulsed once each time o_valid=1. Required grant sequence 0001, 0010, 0100, 1000, 0001, with o_ptr sequence 0, 1, 2, 3, 0, and exactly one o_valid=0 cycle between grants.
- Priority skip and wrap: o_ptr=3, i_req=4'b0011. Required: grant 0001 (bit 3 absent, so the search wraps to 0). After done, o_ptr=1.
- Request withdrawal and reset mid-GRANT:
  - With grant=0010, drop i_req to 0. Required: grant held until i_done.
  - Re-grant, then assert i_rst. Required next edge: o_grant=0, o_valid=0, o_ptr=0.
- LEN=3 instance: i_req=3'b111, repeated done pulses. Required grants 001, 010, 100, 001, and o_ptr never equals 3.
- Invariant checker, all tests: o_grant is zero or one-hot every cycle, and o_valid == (o_grant != 0).
